// File: rtl/b1_boc_replica_gen.sv
// B1 BOC(1,1) local replica generator.
// Half-chip NCO drives a truncated 2046-chip Gold code (two 11-stage LFSRs),
// modulated by a half-chip subcarrier. It produces early/prompt/late replica bits
// one half-chip apart, the prompt chip index and a prompt epoch strobe.
module b1_boc_replica_gen #(
   parameter logic [10:0] G_INIT   = 11'b01010101010,
   parameter int unsigned CODE_LEN = 2046
) (
   input  logic        rx_clk,
   input  logic        rx_rst_n,
   input  logic        rx_en,
   input  logic        rx_init,
   input  logic [31:0] rx_prn_fcw,
   input  logic [3:0]  rx_g2_tap_a,
   input  logic [3:0]  rx_g2_tap_b,
   output logic        tx_loc_bocE,
   output logic        tx_loc_bocP,
   output logic        tx_loc_bocL,
   output logic        tx_prn_sop,
   output logic [10:0] tx_chip_idx
);

   localparam logic [10:0] LAST_CHIP = 11'(CODE_LEN - 1);

   // Registered state; bit k-1 of g1/g2 is LFSR stage k
   logic [31:0] phase;
   logic        half;
   logic [10:0] chipCnt;
   logic [10:0] g1;
   logic [10:0] g2;
   logic        bocE;
   logic        bocP;
   logic        bocL;
   logic        sopE;
   logic        sopPulse;
   logic [10:0] idxE;
   logic [10:0] idxP;

   // Next-state values for a tick
   logic [32:0] ncoSum;
   logic        tick;
   logic        halfNext;
   logic [10:0] chipNext;
   logic [10:0] g1Next;
   logic [10:0] g2Next;
   logic        g1Fb;
   logic        g2Fb;
   logic        earlyNext;
   logic        sopNext;

   // Tap 0 and 12..15 land on the zero padding, so they contribute nothing.
   function automatic logic tapBit(input logic [10:0] g, input logic [3:0] tap);
      logic [15:0] ext;
      ext = {4'b0000, g, 1'b0};
      return ext[tap];
   endfunction

   // NCO sum, LFSR advance and the early sample taken from the post-update state
   always_comb begin
      ncoSum   = {1'b0, phase} + {1'b0, rx_prn_fcw};
      tick     = ncoSum[32];
      halfNext = ~half;
      g1Fb     = g1[0] ^ g1[6] ^ g1[7] ^ g1[8] ^ g1[9] ^ g1[10];
      g2Fb     = g2[0] ^ g2[1] ^ g2[2] ^ g2[3] ^ g2[4] ^ g2[7] ^ g2[8] ^ g2[10];
      chipNext = chipCnt;
      g1Next   = g1;
      g2Next   = g2;
      if (half) begin
         if (chipCnt == LAST_CHIP) begin
            // epoch end: reload instead of shifting truncates 2047 to CODE_LEN
            chipNext = '0;
            g1Next   = G_INIT;
            g2Next   = G_INIT;
         end else begin
            chipNext = chipCnt + 11'd1;
            g1Next   = {g1[9:0], g1Fb};
            g2Next   = {g2[9:0], g2Fb};
         end
      end
      earlyNext = g1Next[10] ^ tapBit(g2Next, rx_g2_tap_a)
                ^ tapBit(g2Next, rx_g2_tap_b) ^ halfNext;
      sopNext   = (chipNext == '0) && !halfNext;
   end

   // State register: init beats enable and tick; the E/P/L chains shift only on tick
   always_ff @(posedge rx_clk or negedge rx_rst_n) begin
      if (!rx_rst_n) begin
         phase    <= '0;
         half     <= 1'b0;
         chipCnt  <= '0;
         g1       <= G_INIT;
         g2       <= G_INIT;
         bocE     <= 1'b0;
         bocP     <= 1'b0;
         bocL     <= 1'b0;
         sopE     <= 1'b0;
         sopPulse <= 1'b0;
         idxE     <= '0;
         idxP     <= '0;
      end else if (rx_init) begin
         phase    <= '0;
         half     <= 1'b0;
         chipCnt  <= '0;
         g1       <= G_INIT;
         g2       <= G_INIT;
         bocE     <= 1'b0;
         bocP     <= 1'b0;
         bocL     <= 1'b0;
         sopE     <= 1'b0;
         sopPulse <= 1'b0;
         idxE     <= '0;
         idxP     <= '0;
      end else if (rx_en) begin
         phase    <= ncoSum[31:0];
         sopPulse <= 1'b0;
         if (tick) begin
            half     <= halfNext;
            chipCnt  <= chipNext;
            g1       <= g1Next;
            g2       <= g2Next;
            bocL     <= bocP;
            bocP     <= bocE;
            bocE     <= earlyNext;
            // strobe carries the flag moving into P, so it lines up with the P update
            sopPulse <= sopE;
            sopE     <= sopNext;
            idxP     <= idxE;
            idxE     <= chipNext;
         end
      end else begin
         // strobe is a single-cycle event even while everything else holds
         sopPulse <= 1'b0;
      end
   end

   assign tx_loc_bocE = bocE;
   assign tx_loc_bocP = bocP;
   assign tx_loc_bocL = bocL;
   assign tx_prn_sop  = sopPulse;
   assign tx_chip_idx = idxP;

endmodule

// File: doc/b1_boc_replica_gen.md
# b1_boc_replica_gen

- Local BOC(1,1) replica generator for the B1 tracking channel.
- Driven by the code-rate FCW from the tracking loop filter.
- Outputs the early, prompt and late replica bits (1 = negate the input sample) and the prompt code-epoch strobe.
- Feeds the correlate-and-dump stage directly.
- Code: B1I-style Gold code, length 2046, built from two 11-stage LFSRs. The subcarrier is applied per half-chip. E/P/L are spaced one half-chip apart.

## Interface
Parameters:
- G_INIT, 11'b01010101010: reload value for G1 and G2. Bit k-1 is stage k.
- CODE_LEN, 2046: chips per epoch.

Ports:
- rx_clk  in  1  sample clock; the only clock.
- rx_rst_n  in  1  reset, asynchronous, active-low.
- rx_en  in  1  advance enable. Low freezes all state; outputs hold.
- rx_init  in  1  one-cycle restart to chip 0, half 0, NCO phase 0.
- rx_prn_fcw  in  32  half-chip NCO frequency control word, unsigned.
- rx_g2_tap_a  in  4  first G2 phase-select stage, 1..11.
- rx_g2_tap_b  in  4  second G2 phase-select stage, 1..11.
- tx_loc_bocE  out  1  early replica bit.
- tx_loc_bocP  out  1  prompt replica bit.
- tx_loc_bocL  out  1  late replica bit.
- tx_prn_sop  out  1  one-cycle strobe: prompt starts chip 0, half 0.
- tx_chip_idx  out  11  prompt chip index, 0..2045.

## Operation
- NCO: 33-bit sum {carry, phase_next} = phase + rx_prn_fcw, computed every enabled cycle. tick = carry. Tick rate = fcw/2^32 × f_clk = twice the chip rate.
- On tick, half toggles.
  - half 1→0: chip advances. Both LFSRs shift (stage k → k+1, feedback into stage 1) and chip_cnt increments.
  - chip_cnt 2045→0: both LFSRs reload G_INIT instead of shifting. This is the truncation of 2047 to 2046.
- G1 feedback = XOR of stages 1, 7, 8, 9, 10, 11.
- G2 feedback = XOR of stages 1, 2, 3, 4, 5, 8, 9, 11.
- code = G1[11] ^ G2[tap_a] ^ G2[tap_b].
  - A tap value of 0 or 12..15 contributes 0.
  - Taps are sampled continuously; change them only with rx_init.
- Early sample = code ^ half, computed from the post-update state.
- Shift chain, updated on tick: L ← P, P ← E, E ← new sample.
  - A parallel sop flag (early at chip 0, half 0) shifts into the P position.
  - A parallel chip-index chain gives tx_chip_idx.
- tx_prn_sop is high for exactly the one cycle in which P is first registered at chip 0, half 0.
- rx_init has priority over tick and over rx_en. It reloads:
  - LFSRs to G_INIT;
  - chip_cnt, half and phase to 0;
  - E/P/L and the sop flags to 0.
  - The first tick after init loads E with chip 0, half 1.
- rx_init and tick in the same cycle: tick is discarded.
- rx_prn_fcw = 0: no ticks; outputs static.
- Any fcw value is legal. Phase wraps modulo 2^32 with no saturation.

## Timing
- Reset values: all outputs 0; phase 0; half 0; chip_cnt 0; LFSRs G_INIT.
- Reset assertion takes effect immediately, mid-epoch included. Deassertion is synchronous to rx_clk by the upstream reset synchroniser.
- Latency: E/P/L change on the rx_clk edge that registers the tick (one cycle after the carry-producing phase). No other pipeline.
- Cadence:
  - P equals E delayed by one tick; L equals E delayed by two ticks.
  - Epoch = 2 × CODE_LEN ticks = 4092 ticks.
- tx_prn_sop:
  - Coincides with the tx_loc_bocP update. The downstream dump uses the same cycle's P bit as the first sample of the new accumulation.
  - Never high two consecutive cycles.
  - Not asserted in the cycles following rx_init until P actually reaches chip 0, half 0.
- rx_en low: phase not accumulated; a pending carry is not generated; sop cannot fire.

## Test plan
- Reset:
  - Stimulus: assert rx_rst_n low mid-epoch with fcw=0x8000_0000.
  - Required: all outputs 0 the same cycle; after release, sequence restarts from chip 0.
- Rate:
  - Stimulus: fcw=0x4000_0000, taps (1,3), rx_en=1, rx_init pulse.
  - Required: tick every 4 cycles; tx_prn_sop period exactly 16368 cycles; tx_chip_idx sequence 0..2045 then 0.
- Code:
  - Stimulus: taps (1,3), fcw=0x8000_0000.
  - Required: first 2046 prompt chips (even-half samples) match the golden G1/G2 model; chip 0 = 0; each chip's second half-sample is inverted.
- Spacing:
  - Stimulus: any run.
  - Required: tx_loc_bocP(t) = tx_loc_bocE(t−1 tick); tx_loc_bocL(t) = tx_loc_bocE(t−2 ticks).
- Edges:
  - Stimulus: rx_init coincident with tick; rx_en low for 100 cycles; fcw=0.
  - Required: tick ignored; all outputs frozen; no sop.
- Wrap:
  - Stimulus: run 3 epochs at fcw=0xFFFF_FFFF.
  - Required: tick on all but one cycle per 2^32; LFSRs reload at chip 2045→0; sop spacing 4092 ticks.
